// File: rtl/fb_pkg.sv
// Shared types and geometry helpers for the double-buffered HUB75 framebuffer.
package fb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      CLEAR     = 2'd1,
      SWAP_WAIT = 2'd2
   } fb_state_e;

   // One bank holds one half-panel: COLS x ROWS/2 pixels.
   function automatic int fb_depth(input int cols, input int rows);
      return cols * rows / 2;
   endfunction

   function automatic int fb_aw(input int cols, input int rows);
      return $clog2(cols * rows / 2);
   endfunction

endpackage

// File: rtl/fb_bank.sv
// Simple dual-port RAM: one synchronous write port, one synchronous read port.
module fb_bank #(
   parameter  int DEPTH = 2048,
   parameter  int DW    = 3,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rdata_q;

   // NOTE: no reset on the array or its read register, so the tools can map this onto block RAM.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/framebuffer_dbuf.sv
// Double-buffered HUB75 framebuffer: renderer writes the back buffer, the panel
// driver reads both halves of the front buffer, swaps happen on frame boundaries.
module framebuffer_dbuf
   import fb_pkg::*;
#(
   parameter  int COLS  = 64,
   parameter  int ROWS  = 64,
   parameter  int CBITS = 3,
   localparam int XW    = $clog2(COLS),
   localparam int YW    = $clog2(ROWS),
   localparam int DEPTH = fb_depth(COLS, ROWS),
   localparam int AW    = fb_aw(COLS, ROWS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [XW-1:0]    wr_x,
   input  logic [YW-1:0]    wr_y,
   input  logic [CBITS-1:0] wr_color,
   input  logic             clr_req,
   input  logic [CBITS-1:0] clr_color,
   output logic             clr_done,
   input  logic             swap_req,
   output logic             swap_done,
   input  logic             frame_done,
   input  logic             rd_en,
   input  logic [XW-1:0]    col_addr,
   input  logic [YW-2:0]    row_addr,
   output logic [CBITS-1:0] rgb_top,
   output logic [CBITS-1:0] rgb_bot,
   output logic             rd_valid,
   output logic             front_sel,
   output logic             busy
);

   fb_state_e        state_q, state_d;
   logic             front_sel_q, front_sel_d;
   logic             swap_pend_q, swap_pend_d;
   logic [AW-1:0]    cnt_q, cnt_d;
   logic [CBITS-1:0] clr_color_q, clr_color_d;
   logic             clr_done_q, clr_done_d;
   logic             swap_done_q, swap_done_d;
   logic             run_q;
   logic             rd_valid_q;
   logic             rd_sel_q;
   logic             rd_seen_q;

   logic             wr_fire;
   logic             clearing;
   logic [AW-1:0]    bank_waddr;
   logic [CBITS-1:0] bank_wdata;
   logic [AW-1:0]    bank_raddr;
   logic [CBITS-1:0] bank_rdata [4];

   assign wr_ready = run_q && (state_q == IDLE);
   assign wr_fire  = wr_valid && wr_ready;
   assign clearing = (state_q == CLEAR);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      front_sel_d = front_sel_q;
      swap_pend_d = swap_pend_q;
      cnt_d       = cnt_q;
      clr_color_d = clr_color_q;
      clr_done_d  = 1'b0;
      swap_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (clr_req) begin
               state_d     = CLEAR;
               clr_color_d = clr_color;
               cnt_d       = '0;
               swap_pend_d = swap_req;
            end else if (swap_req) begin
               state_d = SWAP_WAIT;
            end
         end
         CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            if (swap_req) swap_pend_d = 1'b1;
            if (cnt_q == AW'(DEPTH - 1)) begin
               clr_done_d  = 1'b1;
               cnt_d       = '0;
               swap_pend_d = 1'b0;
               // A swap requested on the final clear cycle must not be lost.
               state_d     = (swap_pend_q || swap_req) ? SWAP_WAIT : IDLE;
            end
         end
         SWAP_WAIT: begin
            if (frame_done) begin
               front_sel_d = ~front_sel_q;
               swap_done_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         front_sel_q <= 1'b0;
         swap_pend_q <= 1'b0;
         cnt_q       <= '0;
         clr_color_q <= '0;
         clr_done_q  <= 1'b0;
         swap_done_q <= 1'b0;
         run_q       <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_sel_q    <= 1'b0;
         rd_seen_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         front_sel_q <= front_sel_d;
         swap_pend_q <= swap_pend_d;
         cnt_q       <= cnt_d;
         clr_color_q <= clr_color_d;
         clr_done_q  <= clr_done_d;
         swap_done_q <= swap_done_d;
         run_q       <= 1'b1;
         rd_valid_q  <= rd_en;
         if (rd_en) begin
            rd_sel_q  <= front_sel_q;
            rd_seen_q <= 1'b1;
         end
      end
   end

   assign bank_waddr = clearing ? cnt_q : {wr_y[YW-2:0], wr_x};
   assign bank_wdata = clearing ? clr_color_q : wr_color;
   assign bank_raddr = {row_addr, col_addr};

   // Bank index is buf*2 + half; only the back buffer is ever written.
   for (genvar b = 0; b < 2; b++) begin : g_buf
      for (genvar h = 0; h < 2; h++) begin : g_half
         logic we;
         assign we = (front_sel_q != 1'(b)) &&
                     (clearing || (wr_fire && (wr_y[YW-1] == 1'(h))));
         fb_bank #(.DEPTH(DEPTH), .DW(CBITS)) u_bank (
            .clk     (clk),
            .we_i    (we),
            .waddr_i (bank_waddr),
            .wdata_i (bank_wdata),
            .re_i    (rd_en),
            .raddr_i (bank_raddr),
            .rdata_o (bank_rdata[b*2 + h])
         );
      end
   end

   // The RAM read register has no reset; mask it until the first read lands.
   assign rgb_top   = rd_seen_q ? (rd_sel_q ? bank_rdata[2] : bank_rdata[0]) : '0;
   assign rgb_bot   = rd_seen_q ? (rd_sel_q ? bank_rdata[3] : bank_rdata[1]) : '0;
   assign rd_valid  = rd_valid_q;
   assign clr_done  = clr_done_q;
   assign swap_done = swap_done_q;
   assign front_sel = front_sel_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_framebuffer_dbuf.sv
// Randomised bench for framebuffer_dbuf against a per-pixel two-buffer array model.
module tb_framebuffer_dbuf;

   localparam int COLS  = 64;
   localparam int ROWS  = 64;
   localparam int CBITS = 3;
   localparam int XW    = 6;
   localparam int YW    = 6;
   localparam int HALF  = ROWS / 2;
   localparam int DEPTH = COLS * ROWS / 2;

   logic             clk;
   logic             rst_n;
   logic             wr_valid;
   logic             wr_ready;
   logic [XW-1:0]    wr_x;
   logic [YW-1:0]    wr_y;
   logic [CBITS-1:0] wr_color;
   logic             clr_req;
   logic [CBITS-1:0] clr_color;
   logic             clr_done;
   logic             swap_req;
   logic             swap_done;
   logic             frame_done;
   logic             rd_en;
   logic [XW-1:0]    col_addr;
   logic [YW-2:0]    row_addr;
   logic [CBITS-1:0] rgb_top;
   logic [CBITS-1:0] rgb_bot;
   logic             rd_valid;
   logic             front_sel;
   logic             busy;

   framebuffer_dbuf #(.COLS(COLS), .ROWS(ROWS), .CBITS(CBITS)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_x       (wr_x),
      .wr_y       (wr_y),
      .wr_color   (wr_color),
      .clr_req    (clr_req),
      .clr_color  (clr_color),
      .clr_done   (clr_done),
      .swap_req   (swap_req),
      .swap_done  (swap_done),
      .frame_done (frame_done),
      .rd_en      (rd_en),
      .col_addr   (col_addr),
      .row_addr   (row_addr),
      .rgb_top    (rgb_top),
      .rgb_bot    (rgb_bot),
      .rd_valid   (rd_valid),
      .front_sel  (front_sel),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference: full image of both buffers plus which one is displayed.
   logic [CBITS-1:0] model [2][ROWS][COLS];
   int               mfront = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_back(input logic [CBITS-1:0] c);
      for (int y = 0; y < ROWS; y++)
         for (int x = 0; x < COLS; x++)
            model[1-mfront][y][x] = c;
   endtask

   task automatic write_px(input int x, input int y, input logic [CBITS-1:0] c);
      check("wr_ready_before_write", 32'(wr_ready), 32'd1);
      wr_valid = 1'b1; wr_x = XW'(x); wr_y = YW'(y); wr_color = c;
      tick();
      wr_valid = 1'b0;
      model[1-mfront][y][x] = c;
   endtask

   task automatic read_px(input int x, input int r);
      rd_en = 1'b1; col_addr = XW'(x); row_addr = (YW-1)'(r);
      tick();
      rd_en = 1'b0;
      check("rd_valid", 32'(rd_valid), 32'd1);
      check("rgb_top", 32'(rgb_top), 32'(model[mfront][r][x]));
      check("rgb_bot", 32'(rgb_bot), 32'(model[mfront][r+HALF][x]));
   endtask

   // Call with the DUT waiting for frame_done; reads the old front in the toggle cycle.
   task automatic finish_swap(input bit check_read);
      int x, r;
      repeat ($urandom_range(0, 3)) tick();
      check("swap_wait_front", 32'(front_sel), 32'(mfront));
      check("swap_wait_busy", 32'(busy), 32'd1);
      x = $urandom_range(0, COLS-1);
      r = $urandom_range(0, HALF-1);
      frame_done = 1'b1; rd_en = 1'b1; col_addr = XW'(x); row_addr = (YW-1)'(r);
      tick();
      frame_done = 1'b0; rd_en = 1'b0;
      check("swap_front_toggle", 32'(front_sel), 32'(1 - mfront));
      check("swap_done_pulse", 32'(swap_done), 32'd1);
      if (check_read) begin
         check("toggle_read_old_top", 32'(rgb_top), 32'(model[mfront][r][x]));
         check("toggle_read_old_bot", 32'(rgb_bot), 32'(model[mfront][r+HALF][x]));
      end
      mfront = 1 - mfront;
      check("swap_idle_ready", 32'(wr_ready), 32'd1);
      check("swap_idle_busy", 32'(busy), 32'd0);
      tick();
      check("swap_done_low", 32'(swap_done), 32'd0);
   endtask

   task automatic do_swap(input bit frame_same, input bit with_write, input bit check_read);
      int x, y;
      logic [CBITS-1:0] c;
      x = $urandom_range(0, COLS-1);
      y = $urandom_range(0, ROWS-1);
      c = CBITS'($urandom);
      swap_req = 1'b1; frame_done = frame_same;
      if (with_write) begin
         wr_valid = 1'b1; wr_x = XW'(x); wr_y = YW'(y); wr_color = c;
      end
      tick();
      if (with_write) model[1-mfront][y][x] = c;
      swap_req = 1'b0; frame_done = 1'b0; wr_valid = 1'b0;
      check("swap_accept_busy", 32'(busy), 32'd1);
      check("swap_accept_ready", 32'(wr_ready), 32'd0);
      check("swap_accept_front", 32'(front_sel), 32'(mfront));
      finish_swap(check_read);
      if (with_write) begin
         // The pixel written alongside swap_req is now on the front buffer.
         read_px(x, y % HALF);
      end
   endtask

   task automatic do_clear(input logic [CBITS-1:0] c, input bit with_swap, input bit mid_swap);
      int n;
      clr_req = 1'b1; clr_color = c; swap_req = with_swap;
      tick();
      clr_req = 1'b0; swap_req = 1'b0; clr_color = CBITS'($urandom);
      check("clr_busy", 32'(busy), 32'd1);
      check("clr_ready_low", 32'(wr_ready), 32'd0);
      n = 0;
      while (!clr_done && n < DEPTH + 16) begin
         if (mid_swap && n == 100) begin
            swap_req = 1'b1; clr_req = 1'b1; clr_color = ~c;
         end
         tick();
         swap_req = 1'b0; clr_req = 1'b0;
         n++;
      end
      check("clr_cycles", 32'(n), 32'(DEPTH));
      fill_back(c);
      tick();
      check("clr_done_low", 32'(clr_done), 32'd0);
      check("clr_after_busy", 32'(busy), 32'(with_swap || mid_swap));
      check("clr_front_kept", 32'(front_sel), 32'(mfront));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int xs [64];
      int ys [64];
      rst_n = 1'b0; wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_color = '0;
      clr_req = 1'b0; clr_color = '0; swap_req = 1'b0; frame_done = 1'b0;
      rd_en = 1'b0; col_addr = '0; row_addr = '0;

      #23;
      check("rst_wr_ready", 32'(wr_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_front", 32'(front_sel), 32'd0);
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_rgb", 32'({rgb_top, rgb_bot}), 32'd0);
      check("rst_pulses", 32'({clr_done, swap_done}), 32'd0);
      rst_n = 1'b1;
      tick();
      check("post_rst_ready", 32'(wr_ready), 32'd1);

      // Clear both buffers to black.
      do_clear('0, 1'b0, 1'b0);
      do_swap(1'b1, 1'b0, 1'b0);
      do_clear('0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) read_px($urandom_range(0, COLS-1), $urandom_range(0, HALF-1));

      // Directed pixel pair in top and bottom halves.
      write_px(5, 3, 3'b101);
      write_px(5, 35, 3'b011);
      do_swap(1'b0, 1'b0, 1'b1);
      read_px(5, 3);
      check("t2_top_lit", 32'(rgb_top), 32'(3'b101));
      check("t2_bot_lit", 32'(rgb_bot), 32'(3'b011));
      tick();
      check("hold_rd_valid", 32'(rd_valid), 32'd0);
      check("hold_rgb_top", 32'(rgb_top), 32'(3'b101));

      // Swap with a write in the accept cycle; early frame_done must be ignored.
      do_swap(1'b1, 1'b1, 1'b1);
      do_swap(1'b0, 1'b1, 1'b1);

      // Combined clear+swap, then full sweep of the front buffer.
      do_clear(3'b111, 1'b1, 1'b0);
      finish_swap(1'b1);
      for (int r = 0; r < HALF; r++)
         for (int x = 0; x < COLS; x++)
            read_px(x, r);

      // Stream writes back-to-back while the display keeps reading the front.
      for (int i = 0; i < 64; i++) begin
         logic [CBITS-1:0] c;
         int rx, rr;
         bit rd;
         xs[i] = $urandom_range(0, COLS-1);
         ys[i] = $urandom_range(0, ROWS-1);
         c = CBITS'($urandom);
         rd = (i % 2 == 0);
         rx = $urandom_range(0, COLS-1);
         rr = $urandom_range(0, HALF-1);
         check("stream_ready", 32'(wr_ready), 32'd1);
         wr_valid = 1'b1; wr_x = XW'(xs[i]); wr_y = YW'(ys[i]); wr_color = c;
         rd_en = rd; col_addr = XW'(rx); row_addr = (YW-1)'(rr);
         tick();
         model[1-mfront][ys[i]][xs[i]] = c;
         if (rd) begin
            check("stream_front_top", 32'(rgb_top), 32'(model[mfront][rr][rx]));
            check("stream_front_bot", 32'(rgb_bot), 32'(model[mfront][rr+HALF][rx]));
         end
      end
      wr_valid = 1'b0; rd_en = 1'b0;
      do_swap(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 64; i++) read_px(xs[i], ys[i] % HALF);

      // Clear with a swap request and an ignored clr_req arriving mid-clear.
      do_clear(CBITS'($urandom), 1'b0, 1'b1);
      finish_swap(1'b1);
      for (int i = 0; i < 16; i++) read_px($urandom_range(0, COLS-1), $urandom_range(0, HALF-1));

      // Reset in the middle of a clear with the display reading buffer 1.
      if (mfront == 0) do_swap(1'b0, 1'b0, 1'b1);
      rd_en = 1'b1; col_addr = XW'($urandom); row_addr = (YW-1)'($urandom);
      clr_req = 1'b1; clr_color = 3'b110;
      tick();
      clr_req = 1'b0;
      repeat (1000) tick();
      check("pre_rst_busy", 32'(busy), 32'd1);
      check("pre_rst_front", 32'(front_sel), 32'd1);
      check("pre_rst_rd_valid", 32'(rd_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_front", 32'(front_sel), 32'd0);
      check("mid_rst_ready", 32'(wr_ready), 32'd0);
      check("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
      check("mid_rst_rgb", 32'({rgb_top, rgb_bot}), 32'd0);
      rd_en = 1'b0;
      tick();
      #2;
      rst_n = 1'b1;
      tick();
      check("rel_ready", 32'(wr_ready), 32'd1);
      check("rel_front", 32'(front_sel), 32'd0);
      check("rel_busy", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
